ap_unsi_wall_pipe: RTL and testbench
====================================

// Module: ap_unsi_wall_pipe
// PURPOSE
//  Pipelined, parametrised unsigned Wallace-tree multiplier with a run-time exact/approximate mode.
//  In approximate mode, the low APX_COLS product columns use per-column OR instead of carry-save
//  compression, and no carry leaves that region.
//  Valid/ready handshake on both sides; drop-in datapath multiplier for the accelerator tiles.
// PARAMETERS
//  DW        12  operand width in bits; result is 2*DW bits
//  APX_COLS  10  number of approximated low columns, 0..DW (0 = always exact)
// PORTS
//  clk      in   1       single clock, rising edge
//  rst      in   1       asynchronous, active-high reset
//  in_vld   in   1       operand beat valid
//  in_rdy   out  1       block accepts operand beat
//  apx      in   1       1 = approximate mode for this beat, 0 = exact
//  muld     in   DW      multiplicand, unsigned
//  mulr     in   DW      multiplier, unsigned
//  out_vld  out  1       result valid
//  out_rdy  in   1       downstream accepts result
//  res      out  2*DW    product
// BEHAVIOUR
//  - Reset: every valid bit, res and all pipeline registers are cleared to 0 asynchronously.
//  - Pipeline, 3 register stages:
//    - S1: register muld, mulr, apx, vld.
//    - S2: build DW*DW partial-product bits pp[i][j] = muld[i] & mulr[j]; reduce to sum/carry rows
//      and register them.
//    - S3: final carry-propagate add; register into res/out_vld.
//  - Latency 3 cycles from accepted beat to out_vld while out_rdy=1; throughput 1 beat per cycle.
//  - Global stall: adv = out_rdy | ~out_vld; in_rdy = adv.
//    - All stages load only when adv=1; a beat is accepted when in_vld & in_rdy.
//    - Bubbles carry vld=0.
//  - While out_vld=1 and out_rdy=0, res and out_vld hold; no beat is lost or duplicated.
//  - Exact mode (apx=0): res = muld*mulr, full 2*DW bits.
//  - Approximate mode (apx=1):
//    - Column k < APX_COLS: res[k] = OR of all pp[i][j] with i+j=k; no carry from these columns.
//    - Columns k >= APX_COLS: exact Wallace reduction of their own pp bits, plus carries
//      generated within those columns only.
//    - Guaranteed: approx result <= exact result, so no overflow.
//  - Mode is carried per beat; mixed exact/approx streams are legal back-to-back.
//  - APX_COLS=0: the apx input is ignored and the result is always exact.
//  - Reset mid-operation: in-flight beats are discarded; out_vld=0 until new beats traverse.
// CONFIGURATION
//  - AP_ERR_COMP_EN defined: in approximate mode the S3 adder also adds the constant
//    2^(APX_COLS-1) when APX_COLS>0, halving mean error. This cannot overflow because
//    APX_COLS <= DW. Exact mode is unaffected.
//  - AP_ERR_COMP_EN undefined: no compensation; the adder has two operands only.
// STRUCTURE
//  - Package ap_mult_pkg:
//    - function ap_col_height(k, DW): pp count in column k
//    - localparam-friendly clog2 helper
//    - typedef for the {sum, carry} row pair
//  - One sub-module ap_csa_tree #(DW, APX_COLS): combinational pp generation plus split
//    OR/Wallace reduction to two rows, instantiated in S2. Pipeline and handshake logic stay
//    in this module.
//  - Elaboration check: APX_COLS <= DW, else $fatal.
// TESTING (DW=12, APX_COLS=10)
//  - Exact mode:
//    - muld=0xFFF, mulr=0xFFF -> res=0xFFE001 after 3 cycles.
//    - muld=0, mulr=0x5A5 -> res=0.
//  - Approx mode:
//    - muld=3, mulr=3 -> res=7; exact would be 9.
//    - With AP_ERR_COMP_EN -> res=519.
//  - Approx mode, muld=1, mulr=0x3FF -> res=0x3FF; single pp per column, so no error.
//  - Back-to-back stream of 8 beats alternating apx, out_rdy=1 -> one result per cycle,
//    in order, each matching the reference model.
//  - Backpressure:
//    - Fill pipe, then hold out_rdy=0 for 5 cycles -> in_rdy=0, res/out_vld stable.
//    - Release -> results drain in order with none lost.
//  - Assert rst with 2 beats in flight -> out_vld=0 immediately; after release no stale result appears.

Source files
------------

// File: rtl/ap_unsi_wall_pipe_pkg.sv
// Shared types and helpers for the approximate Wallace multiplier.
// Imported by ap_csa_tree and ap_unsi_wall_pipe.
package ap_mult_pkg;

  // Selects one row of the {sum, carry} pair leaving the reduction tree.
  typedef enum logic {
    ROW_SUM = 1'b0,
    ROW_CRY = 1'b1
  } ap_row_e;

  function automatic int ap_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Number of partial-product bits landing in column k.
  function automatic int ap_col_height(input int k, input int dw);
    if (k < dw) return k + 1;
    else if (k < 2 * dw - 1) return 2 * dw - 1 - k;
    else return 0;
  endfunction

endpackage

// File: rtl/ap_unsi_wall_pipe_csa_tree.sv
// Partial products plus split OR / carry-save reduction to two rows.
// Low APX_COLS columns are ORed in approximate mode and feed no carries.
module ap_csa_tree
  import ap_mult_pkg::*;
#(
  parameter int DW       = 12,
  parameter int APX_COLS = 10
) (
  input  logic [DW-1:0]          i_muld,
  input  logic [DW-1:0]          i_mulr,
  input  logic                   i_apx,
  output logic [1:0][2*DW-1:0]   o_rows
);

  localparam int W  = 2 * DW;
  localparam int MH = DW + 2;
  localparam int NR = 3 * ap_clog2(DW) + 3;

  logic [MH-1:0] w_m [W];
  logic [MH-1:0] w_n [W];
  int            w_h [W];
  int            w_g [W];
  logic [W-1:0]  w_or;
  logic          w_en;

  // Column-wise 3:2 compression until every column holds at most two bits.
  always_comb begin
    w_en   = i_apx && (APX_COLS > 0);
    w_or   = '0;
    o_rows = '0;
    for (int k = 0; k < W; k++) begin
      w_m[k] = '0;
      w_n[k] = '0;
      w_h[k] = ap_col_height(k, DW);
      w_g[k] = 0;
    end
    for (int i = 0; i < DW; i++)
      for (int j = 0; j < DW; j++)
        if (w_en && (i + j) < APX_COLS)
          w_or[i+j] = w_or[i+j] | (i_muld[i] & i_mulr[j]);
        else
          w_m[i+j][(i + j < DW) ? i : DW - 1 - j] =
            i_muld[i] & i_mulr[j];
    for (int r = 0; r < NR; r++) begin
      for (int k = 0; k < W; k++) begin
        w_n[k] = '0;
        w_g[k] = 0;
      end
      for (int k = 0; k < W; k++) begin
        for (int t = 0; t < MH / 3; t++)
          if (3 * t + 2 < w_h[k]) begin
            w_n[k][w_g[k]] = w_m[k][3*t] ^ w_m[k][3*t+1]
                           ^ w_m[k][3*t+2];
            w_g[k] = w_g[k] + 1;
            if (k + 1 < W) begin
              w_n[k+1][w_g[k+1]] =
                (w_m[k][3*t]   & w_m[k][3*t+1]) |
                (w_m[k][3*t]   & w_m[k][3*t+2]) |
                (w_m[k][3*t+1] & w_m[k][3*t+2]);
              w_g[k+1] = w_g[k+1] + 1;
            end
          end
        for (int t = 0; t < MH; t++)
          if (t >= 3 * (w_h[k] / 3) && t < w_h[k]) begin
            w_n[k][w_g[k]] = w_m[k][t];
            w_g[k] = w_g[k] + 1;
          end
      end
      for (int k = 0; k < W; k++) begin
        w_m[k] = w_n[k];
        w_h[k] = w_g[k];
      end
    end
    for (int k = 0; k < W; k++) begin
      o_rows[ROW_SUM][k] = w_m[k][0] | w_or[k];
      o_rows[ROW_CRY][k] = w_m[k][1];
    end
  end

endmodule

// File: rtl/ap_unsi_wall_pipe.sv
// 3-stage unsigned Wallace multiplier, run-time exact/approximate mode.
// Optional AP_ERR_COMP_EN: approx beats add 2^(APX_COLS-1) in the final adder.
module ap_unsi_wall_pipe
  import ap_mult_pkg::*;
#(
  parameter int DW       = 12,
  parameter int APX_COLS = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic            apx,
  input  logic [DW-1:0]   muld,
  input  logic [DW-1:0]   mulr,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [2*DW-1:0] res
);

  localparam int W = 2 * DW;

  if (APX_COLS < 0 || APX_COLS > DW) begin : g_bad_cfg
    $fatal(1, "ap_unsi_wall_pipe: APX_COLS must lie in 0..DW");
  end

  logic            w_adv;
  logic [DW-1:0]   r1_muld;
  logic [DW-1:0]   r1_mulr;
  logic            r1_apx;
  logic            r1_vld;
  logic [1:0][W-1:0] w_rows;
  logic [1:0][W-1:0] r2_rows;
  logic            r2_vld;
  logic [W-1:0]    w_sum;
  logic [W-1:0]    r_res;
  logic            r_vld;

  // One global stall: nothing moves while a result waits downstream.
  assign w_adv   = out_rdy | ~r_vld;
  assign in_rdy  = w_adv;
  assign out_vld = r_vld;
  assign res     = r_res;

  // S1: capture operands, mode and valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_muld <= '0;
      r1_mulr <= '0;
      r1_apx  <= 1'b0;
      r1_vld  <= 1'b0;
    end else if (w_adv) begin
      r1_muld <= muld;
      r1_mulr <= mulr;
      r1_apx  <= apx;
      r1_vld  <= in_vld;
    end
  end

  ap_csa_tree #(
    .DW       (DW),
    .APX_COLS (APX_COLS)
  ) u_tree (
    .i_muld (r1_muld),
    .i_mulr (r1_mulr),
    .i_apx  (r1_apx),
    .o_rows (w_rows)
  );

  // S2: register the reduced sum/carry rows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r2_rows <= '0;
      r2_vld  <= 1'b0;
    end else if (w_adv) begin
      r2_rows <= w_rows;
      r2_vld  <= r1_vld;
    end
  end

`ifdef AP_ERR_COMP_EN
  localparam logic [W-1:0] COMP = (APX_COLS > 0) ?
    W'(1) << ((APX_COLS > 0) ? APX_COLS - 1 : 0) : '0;

  logic r2_apx;

  // Mode travels with the beat so compensation applies per result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r2_apx <= 1'b0;
    else if (w_adv) r2_apx <= r1_apx;
  end

  // S3 adder with bias for approximate beats.
  always_comb begin
    w_sum = r2_rows[ROW_SUM] + r2_rows[ROW_CRY];
    if (r2_apx) w_sum = w_sum + COMP;
  end
`else
  // S3 two-operand carry-propagate adder.
  always_comb begin
    w_sum = r2_rows[ROW_SUM] + r2_rows[ROW_CRY];
  end
`endif

  // S3: final product and output valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res <= '0;
      r_vld <= 1'b0;
    end else if (w_adv) begin
      r_res <= w_sum;
      r_vld <= r2_vld;
    end
  end

endmodule

// File: tb/tb_ap_unsi_wall_pipe.sv
// Scoreboard bench for ap_unsi_wall_pipe (DW=12, APX_COLS=10).
// Honours AP_ERR_COMP_EN for the expected values.
module tb_ap_unsi_wall_pipe;

  localparam int DW  = 12;
  localparam int APX = 10;

  logic        clk;
  logic        rst;
  logic        in_vld;
  logic        in_rdy;
  logic        apx;
  logic [11:0] muld;
  logic [11:0] mulr;
  logic        out_vld;
  logic        out_rdy;
  logic [23:0] res;

  logic [23:0] sb [$];
  int n_vec;
  int n_err;

  ap_unsi_wall_pipe #(.DW(DW), .APX_COLS(APX)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .apx     (apx),
    .muld    (muld),
    .mulr    (mulr),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .res     (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact product, or OR-low / exact-high split.
  function automatic logic [23:0] model(input logic [11:0] a,
                                        input logic [11:0] b,
                                        input logic ap);
    logic [23:0] lo;
    logic [23:0] hi;
    if (!ap || APX == 0) return 24'(a) * 24'(b);
    lo = '0;
    hi = '0;
    for (int i = 0; i < DW; i++)
      for (int j = 0; j < DW; j++)
        if (a[i] & b[j]) begin
          if (i + j < APX) lo[i+j] = 1'b1;
          else hi = hi + (24'(1) << (i + j));
        end
`ifdef AP_ERR_COMP_EN
    return hi + lo + (24'(1) << (APX - 1));
`else
    return hi + lo;
`endif
  endfunction

  // One cycle: drive, sample, push accepted beat, advance.
  task automatic step(input logic v, input logic ap,
                      input logic [11:0] a, input logic [11:0] b,
                      input logic ordy, input logic [23:0] exp,
                      output logic fire, output logic [23:0] got,
                      output logic ovld, output logic irdy);
    in_vld  = v;
    apx     = ap;
    muld    = a;
    mulr    = b;
    out_rdy = ordy;
    #1;
    ovld = out_vld;
    irdy = in_rdy;
    got  = res;
    fire = out_vld && out_rdy;
    if (v && in_rdy) sb.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_vld = 1'b0; apx = 1'b0; muld = '0; mulr = '0; out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (out_vld !== 1'b0) begin
      n_err++; $display("FAIL reset_out_vld: got %b want 0", out_vld);
    end
    n_vec++;
    if (res !== 24'h0) begin
      n_err++; $display("FAIL reset_res: got %h want 000000", res);
    end
    n_vec++;
    if (in_rdy !== 1'b1) begin
      n_err++; $display("FAIL reset_in_rdy: got %b want 1", in_rdy);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_exact();
    logic f, v, r;
    logic [23:0] g, e;
    int lat;
    lat = -1;
    for (int c = 0; c < 8; c++) begin
      if (c == 0)
        step(1, 0, 12'hFFF, 12'hFFF, 1, 24'hFFE001, f, g, v, r);
      else if (c == 1)
        step(1, 0, 12'h000, 12'h5A5, 1, 24'h000000, f, g, v, r);
      else
        step(0, 0, 12'h0, 12'h0, 1, 24'h0, f, g, v, r);
      if (f) begin
        if (lat < 0) lat = c;
        n_vec++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL exact_extra: got %h want none", g);
        end else begin
          e = sb.pop_front();
          if (g !== e) begin
            n_err++; $display("FAIL exact_res: got %h want %h", g, e);
          end
        end
      end
    end
    n_vec++;
    if (lat !== 3) begin
      n_err++; $display("FAIL exact_latency: got %0d want 3", lat);
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL exact_lost: got %0d left want 0", sb.size());
    end
  endtask

  task automatic test_approx();
    logic f, v, r;
    logic [23:0] g, e;
    logic [23:0] e33;
    logic [23:0] e3ff;
`ifdef AP_ERR_COMP_EN
    e33  = 24'd519;
    e3ff = 24'h0005FF;
`else
    e33  = 24'd7;
    e3ff = 24'h0003FF;
`endif
    for (int c = 0; c < 7; c++) begin
      if (c == 0)
        step(1, 1, 12'd3, 12'd3, 1, e33, f, g, v, r);
      else if (c == 1)
        step(1, 1, 12'd1, 12'h3FF, 1, e3ff, f, g, v, r);
      else if (c == 2)
        step(1, 0, 12'd3, 12'd3, 1, 24'd9, f, g, v, r);
      else
        step(0, 0, 12'h0, 12'h0, 1, 24'h0, f, g, v, r);
      if (f) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL approx_extra: got %h want none", g);
        end else begin
          e = sb.pop_front();
          if (g !== e) begin
            n_err++; $display("FAIL approx_res: got %h want %h", g, e);
          end
        end
      end
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL approx_lost: got %0d left want 0", sb.size());
    end
  endtask

  task automatic test_back_to_back();
    logic f, v, r;
    logic [23:0] g, e;
    logic [11:0] a, b;
    int nf, first, last;
    nf = 0; first = -1; last = -1;
    for (int c = 0; c < 11; c++) begin
      a = 12'($urandom);
      b = 12'($urandom);
      if (c < 8) step(1, c[0], a, b, 1, model(a, b, c[0]), f, g, v, r);
      else step(0, 0, 12'h0, 12'h0, 1, 24'h0, f, g, v, r);
      if (f) begin
        nf++;
        if (first < 0) first = c;
        last = c;
        n_vec++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL b2b_extra: got %h want none", g);
        end else begin
          e = sb.pop_front();
          if (g !== e) begin
            n_err++; $display("FAIL b2b_res: got %h want %h", g, e);
          end
        end
      end
    end
    n_vec++;
    if (nf !== 8 || first !== 3 || last !== 10) begin
      n_err++;
      $display("FAIL b2b_rate: got %0d results cyc %0d..%0d want 8 cyc 3..10",
               nf, first, last);
    end
  endtask

  task automatic test_backpressure();
    logic f, v, r, ap;
    logic [23:0] g, e;
    logic [11:0] a, b;
    int nf;
    nf = 0;
    for (int c = 0; c < 3; c++) begin
      a = 12'($urandom); b = 12'($urandom); ap = c[0];
      step(1, ap, a, b, 1, model(a, b, ap), f, g, v, r);
    end
    for (int c = 0; c < 5; c++) begin
      a = 12'($urandom); b = 12'($urandom);
      step(1, 0, a, b, 0, model(a, b, 0), f, g, v, r);
      n_vec++;
      if (r !== 1'b0) begin
        n_err++; $display("FAIL bp_in_rdy: got %b want 0", r);
      end
      n_vec++;
      if (v !== 1'b1) begin
        n_err++; $display("FAIL bp_out_vld: got %b want 1", v);
      end
      n_vec++;
      if (sb.size() == 0 || g !== sb[0]) begin
        n_err++; $display("FAIL bp_res_hold: got %h want %h", g,
                          (sb.size() == 0) ? 24'h0 : sb[0]);
      end
    end
    for (int c = 0; c < 8; c++) begin
      step(0, 0, 12'h0, 12'h0, 1, 24'h0, f, g, v, r);
      if (f) begin
        nf++;
        n_vec++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL bp_extra: got %h want none", g);
        end else begin
          e = sb.pop_front();
          if (g !== e) begin
            n_err++; $display("FAIL bp_drain: got %h want %h", g, e);
          end
        end
      end
    end
    n_vec++;
    if (nf !== 3 || sb.size() != 0) begin
      n_err++;
      $display("FAIL bp_count: got %0d results %0d left want 3 and 0",
               nf, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    logic f, v, r;
    logic [23:0] g, e;
    logic [11:0] a, b;
    int nf;
    nf = 0;
    for (int c = 0; c < 3; c++) begin
      a = 12'($urandom); b = 12'($urandom);
      step(1, 0, a, b, 1, model(a, b, 0), f, g, v, r);
    end
    in_vld = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (out_vld !== 1'b0) begin
      n_err++; $display("FAIL rstmid_out_vld: got %b want 0", out_vld);
    end
    n_vec++;
    if (res !== 24'h0) begin
      n_err++; $display("FAIL rstmid_res: got %h want 000000", res);
    end
    sb.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int c = 0; c < 6; c++) begin
      step(0, 0, 12'h0, 12'h0, 1, 24'h0, f, g, v, r);
      if (f) nf++;
    end
    n_vec++;
    if (nf !== 0) begin
      n_err++; $display("FAIL rstmid_stale: got %0d results want 0", nf);
    end
    for (int c = 0; c < 5; c++) begin
      if (c == 0) step(1, 0, 12'd5, 12'd7, 1, 24'd35, f, g, v, r);
      else step(0, 0, 12'h0, 12'h0, 1, 24'h0, f, g, v, r);
      if (f) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL rstmid_extra: got %h want none", g);
        end else begin
          e = sb.pop_front();
          if (g !== e) begin
            n_err++; $display("FAIL rstmid_after: got %h want %h", g, e);
          end
        end
      end
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL rstmid_lost: got %0d left want 0", sb.size());
    end
  endtask

  task automatic test_random();
    logic f, v, r, ap, iv, ordy;
    logic [23:0] g, e;
    logic [11:0] a, b;
    for (int c = 0; c < 90; c++) begin
      a = 12'($urandom); b = 12'($urandom);
      ap = 1'($urandom_range(0, 1));
      iv = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      if (c >= 80) begin iv = 1'b0; ordy = 1'b1; end
      step(iv, ap, a, b, ordy, model(a, b, ap), f, g, v, r);
      if (f) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL rand_extra: got %h want none", g);
        end else begin
          e = sb.pop_front();
          if (g !== e) begin
            n_err++; $display("FAIL rand_res: got %h want %h", g, e);
          end
        end
      end
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL rand_lost: got %0d left want 0", sb.size());
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_exact();
    test_approx();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timeout");
  end

endmodule
